// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
//
// Shares the register file's single write port between two writeback
// requesters. src0 (ALU/execute path) has fixed priority. src1
// (load/multi-cycle unit) is protected by a starvation guard. Once src1 has
// waited STARVE_LIMIT consecutive cycles, the arbiter enters FORCE1 and src1
// wins the next cycle.
//
// The write port is driven from registers. A handshake at edge k makes
// W_en/Address_write/data_write valid for the cycle after edge k, so the
// register file samples the write at edge k+1. Writes to x0 complete their
// handshake but never raise W_en.
//
// Parameters
//   STARVE_LIMIT  cycles src1 may wait before a grant is forced (1..15)
//   CNT_W         starvation counter width; must be able to hold STARVE_LIMIT
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous reset, active low
//   src0_valid     src0 write pending
//   src0_addr      src0 destination register
//   src0_data      src0 write data
//   src0_ready     src0 granted this cycle (combinational)
//   src1_valid     src1 write pending
//   src1_addr      src1 destination register
//   src1_data      src1 write data
//   src1_ready     src1 granted this cycle (combinational)
//   W_en           register-file write enable (registered)
//   Address_write  register-file write address (registered)
//   data_write     register-file write data (registered)
//   starved        high while the FORCE1 state is active (registered)
// -----------------------------------------------------------------------------
module rf_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        src0_valid,
    input  logic [4:0]  src0_addr,
    input  logic [31:0] src0_data,
    output logic        src0_ready,
    input  logic        src1_valid,
    input  logic [4:0]  src1_addr,
    input  logic [31:0] src1_data,
    output logic        src1_ready,
    output logic        W_en,
    output logic [4:0]  Address_write,
    output logic [31:0] data_write,
    output logic        starved
);

    typedef enum logic {
        PRI0   = 1'b0,
        FORCE1 = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t           state;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             xfer0;
    logic             xfer1;
    logic             any_xfer;
    logic [4:0]       sel_addr;
    logic [31:0]      sel_data;

    // Grant logic. Each ready is qualified by its own valid, so a ready can
    // never be high without a pending request.
    always_comb begin
        // NOTE: every output of an always_comb gets a default first, so no
        // path can leave it unassigned and infer a latch.
        src0_ready = src0_valid;
        src1_ready = src1_valid & ~src0_valid;
        if (state == FORCE1) begin
            src1_ready = src1_valid;
            src0_ready = src0_valid & ~src1_valid;
        end
    end

    assign xfer0    = src0_valid & src0_ready;
    assign xfer1    = src1_valid & src1_ready;
    assign any_xfer = xfer0 | xfer1;

    // At most one transfer happens per cycle, so a single select is enough.
    assign sel_addr = xfer1 ? src1_addr : src0_addr;
    assign sel_data = xfer1 ? src1_data : src0_data;

    // The counter tracks consecutive cycles in which src1 was refused and
    // saturates at the limit. It clears once src1 is served or withdraws.
    always_comb begin
        cnt_next = '0;
        if (src1_valid && !xfer1) begin
            cnt_next = (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 1'b1;
        end
    end

    // The FSM switches on the same edge where the counter reaches the limit.
    // src1 therefore wins in cycle STARVE_LIMIT+1 of its wait.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= PRI0;
            starved       <= 1'b0;
            starve_cnt    <= '0;
            W_en          <= 1'b0;
            Address_write <= '0;
            data_write    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // register samples the pre-edge values of the others.
            starve_cnt <= cnt_next;

            unique case (state)
                PRI0: begin
                    if (cnt_next == LIMIT) begin
                        state   <= FORCE1;
                        starved <= 1'b1;
                    end
                end
                FORCE1: begin
                    if (xfer1 || !src1_valid) begin
                        state   <= PRI0;
                        starved <= 1'b0;
                    end
                end
                default: begin
                    state   <= PRI0;
                    starved <= 1'b0;
                end
            endcase

            // A write to x0 is accepted, but it must not reach the file.
            // Address and data still update so the accepted write shows in traces.
            W_en <= any_xfer && (sel_addr != 5'd0);
            if (any_xfer) begin
                Address_write <= sel_addr;
                data_write    <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_wb_arbiter
//
// Self-checking bench for rf_wb_arbiter. Two requester models hold each
// request until it is granted. A reference model derives the expected grants
// from these rules:
//   - src0 wins unless src1 has already waited STARVE_LIMIT cycles.
//   - A granted write appears on the port for the following cycle.
//   - x0 writes are invisible to W_en.
// -----------------------------------------------------------------------------
module tb_rf_wb_arbiter;

    localparam int LIMIT = 4;

    logic        clk;
    logic        rst;
    logic        src0_valid;
    logic [4:0]  src0_addr;
    logic [31:0] src0_data;
    logic        src0_ready;
    logic        src1_valid;
    logic [4:0]  src1_addr;
    logic [31:0] src1_data;
    logic        src1_ready;
    logic        W_en;
    logic [4:0]  Address_write;
    logic [31:0] data_write;
    logic        starved;

    rf_wb_arbiter #(
        .STARVE_LIMIT(LIMIT),
        .CNT_W       (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .src0_valid   (src0_valid),
        .src0_addr    (src0_addr),
        .src0_data    (src0_data),
        .src0_ready   (src0_ready),
        .src1_valid   (src1_valid),
        .src1_addr    (src1_addr),
        .src1_data    (src1_data),
        .src1_ready   (src1_ready),
        .W_en         (W_en),
        .Address_write(Address_write),
        .data_write   (data_write),
        .starved      (starved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Requester state: a pending request is held until the model grants it.
    logic        p0, p1;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;

    // Reference model: how long src1 has waited, plus the write expected on
    // the port.
    int          wait1;
    logic        exp_wen;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;

    // DUT observations from the most recent cycle, used by the directed steps.
    logic        last_r1;
    logic        last_st;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        wait1    = 0;
        exp_wen  = 1'b0;
        exp_addr = '0;
        exp_data = '0;
    endtask

    task automatic drive();
        src0_valid = p0;
        src0_addr  = a0;
        src0_data  = d0;
        src1_valid = p1;
        src1_addr  = a1;
        src1_data  = d1;
    endtask

    // One clock cycle: drive the requests, check the grants mid-cycle, let
    // the edge pass, then check the registered write port.
    task automatic cycle();
        logic forced, g0, g1;
        drive();
        #1;
        forced = (wait1 >= LIMIT);
        g1 = p1 && (!p0 || forced);
        g0 = p0 && !g1;
        check("src0_ready", 32'(src0_ready), 32'(g0));
        check("src1_ready", 32'(src1_ready), 32'(g1));
        check("starved", 32'(starved), 32'(forced));
        last_r1 = src1_ready;
        last_st = starved;
        @(posedge clk);
        wait1 = (p1 && !g1) ? wait1 + 1 : 0;
        if (g0) begin
            exp_wen = (a0 != 5'd0); exp_addr = a0; exp_data = d0; p0 = 1'b0;
        end else if (g1) begin
            exp_wen = (a1 != 5'd0); exp_addr = a1; exp_data = d1; p1 = 1'b0;
        end else begin
            exp_wen = 1'b0;
        end
        #1;
        check("W_en", 32'(W_en), 32'(exp_wen));
        check("Address_write", 32'(Address_write), 32'(exp_addr));
        check("data_write", 32'(data_write), exp_data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int waits;
        int k;
        int wen_count;
        bit done;

        // Reset is held with both requesters asserting valid.
        model_reset();
        rst = 1'b0;
        p0 = 1'b1; a0 = 5'd3; d0 = 32'h0000_0011;
        p1 = 1'b1; a1 = 5'd9; d1 = 32'h0000_0022;
        last_r1 = 1'b0; last_st = 1'b0;
        drive();
        #12;
        check("rst_src0_ready", 32'(src0_ready), 32'd1);
        check("rst_src1_ready", 32'(src1_ready), 32'd0);
        check("rst_W_en", 32'(W_en), 32'd0);
        check("rst_addr", 32'(Address_write), 32'd0);
        check("rst_data", data_write, 32'd0);
        check("rst_starved", 32'(starved), 32'd0);
        @(posedge clk);
        #3;
        check("rst_W_en_edge", 32'(W_en), 32'd0);
        rst = 1'b1;
        cycle();                       // src0 x3 transfers at the first edge
        check("first_write_en", 32'(W_en), 32'd1);
        check("first_write_addr", 32'(Address_write), 32'd3);
        cycle();                       // src1 x9 follows
        cycle();                       // idle

        // A single src0 write, with src1 idle.
        p0 = 1'b1; a0 = 5'd5; d0 = 32'hDEAD_BEEF;
        cycle();
        check("single_wen", 32'(W_en), 32'd1);
        check("single_addr", 32'(Address_write), 32'd5);
        check("single_data", data_write, 32'hDEAD_BEEF);
        cycle();
        check("single_wen_drop", 32'(W_en), 32'd0);
        check("single_hold_data", data_write, 32'hDEAD_BEEF);

        // Contention: src0 requests every cycle while src1 holds x7.
        p1 = 1'b1; a1 = 5'd7; d1 = 32'h0000_1234;
        k = 1; waits = 0; done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (!p0) begin p0 = 1'b1; a0 = 5'(k); d0 = 32'(k) * 32'h0101_0101; k++; end
            cycle();
            if (last_r1) done = 1'b1;
            else waits++;
        end
        check("starve_wait", 32'(waits), 32'(LIMIT));
        check("starved_at_force", 32'(last_st), 32'd1);
        check("force_write_addr", 32'(Address_write), 32'd7);
        check("force_write_data", data_write, 32'h0000_1234);
        cycle();                       // the loser src0 resumes in PRI0
        check("resume_starved", 32'(starved), 32'd0);

        // x0 write: accepted, but W_en stays low.
        p1 = 1'b1; a1 = 5'd0; d1 = 32'hFFFF_FFFF;
        cycle();
        check("x0_ready", 32'(last_r1), 32'd1);
        check("x0_wen", 32'(W_en), 32'd0);
        check("x0_addr", 32'(Address_write), 32'd0);
        check("x0_data", data_write, 32'hFFFF_FFFF);

        // Asynchronous reset in FORCE1 while a write is pending on the port.
        p1 = 1'b1; a1 = 5'd9; d1 = 32'h0BAD_F00D;
        for (int i = 0; i < 20 && wait1 < LIMIT; i++) begin
            if (!p0) begin p0 = 1'b1; a0 = 5'(20 + i); d0 = $urandom; end
            cycle();
        end
        check("pre_rst_starved", 32'(starved), 32'd1);
        check("pre_rst_wen", 32'(W_en), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_wen", 32'(W_en), 32'd0);
        check("async_rst_starved", 32'(starved), 32'd0);
        check("async_rst_addr", 32'(Address_write), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 8 && (p0 || p1); i++) cycle();

        // Streaming: src0 and src1 alternate with no overlap.
        wen_count = 0;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin p0 = 1'b1; a0 = 5'(i + 1);  d0 = $urandom; end
            else            begin p1 = 1'b1; a1 = 5'(i + 10); d1 = $urandom; end
            cycle();
            if (W_en) wen_count++;
        end
        check("stream_wen_count", 32'(wen_count), 32'd8);

        // Random traffic: a light-load phase, then a heavy-contention phase.
        for (int i = 0; i < 600; i++) begin
            int hi;
            hi = (i < 300) ? 2 : 9;
            if (!p0 && $urandom_range(0, 9) < hi)
                begin p0 = 1'b1; a0 = 5'($urandom_range(0, 31)); d0 = $urandom; end
            if (!p1 && $urandom_range(0, 9) < hi)
                begin p1 = 1'b1; a1 = 5'($urandom_range(0, 31)); d1 = $urandom; end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: src0 (ALU/execute path) and src1 (load/multi-cycle unit).
- Fixed priority to src0, with a starvation guard that forces a src1 grant after a bounded wait.
- Drives the register file write port from registers, so a write reaches the file one cycle after its handshake.
- Sits between the execute/memory stages and the register file.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles src1 may be valid but not granted before a src1 grant is forced; legal range 1..15.
- CNT_W, 4: width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset. One clock; reset is asynchronous and active-low.
- src0_valid  in  1  src0 has a write pending.
- src0_addr  in  5  src0 destination register.
- src0_data  in  32  src0 write data.
- src0_ready  out  1  src0 granted this cycle (combinational).
- src1_valid  in  1  src1 has a write pending.
- src1_addr  in  5  src1 destination register.
- src1_data  in  32  src1 write data.
- src1_ready  out  1  src1 granted this cycle (combinational).
- W_en  out  1  register-file write enable (registered).
- Address_write  out  5  register-file write address (registered).
- data_write  out  32  register-file write data (registered).
- starved  out  1  high while the FORCE1 state is active (registered state).

Behaviour:
- Reset (rst=0, asynchronous):
  - W_en=0, Address_write=0, data_write=0.
  - Starvation counter=0; state=PRI0; starved=0.
  - Takes effect immediately, including mid-handshake. The in-flight registered write is discarded and no write issues on the first edge after release.
- Handshake:
  - A transfer occurs on a rising edge when srcN_valid & srcN_ready.
  - Requesters hold addr/data stable while valid is high and ready is low.
  - At most one transfer per cycle.
- Grant logic (combinational from state and valids):
  - PRI0: src0_ready = src0_valid; src1_ready = src1_valid & ~src0_valid.
  - FORCE1: src1_ready = src1_valid; src0_ready = src0_valid & ~src1_valid.
  - A ready is never high without its valid.
- State machine:
  - PRI0 -> FORCE1 when the counter equals STARVE_LIMIT at the clock edge.
  - FORCE1 -> PRI0 on a src1 transfer, or when src1_valid is low.
  - starved = (state==FORCE1).
- Starvation counter:
  - Increments each cycle src1_valid & ~src1_ready, saturating at STARVE_LIMIT.
  - Clears on a src1 transfer or when src1_valid=0.
- Output register, next edge after a transfer:
  - W_en = 1 if the granted address is nonzero, else 0.
  - Address_write/data_write load the granted values.
- Writes to x0:
  - Accepted (ready asserted, handshake completes) but W_en stays 0.
  - Address_write/data_write still update, for trace visibility.
- No transfer this cycle: W_en=0 next cycle; Address_write/data_write hold their last values.
- Latency: handshake at edge k, register-file write at edge k+1.
- Simultaneous valids: exactly one is granted, per the current state. The loser's request persists until it is granted.
- Back-to-back transfers at full rate are required, with no bubbles.
- Both requesters targeting the same register in consecutive cycles: writes land in grant order, so the later grant wins.
- Worst-case src1 wait with src0 permanently valid: STARVE_LIMIT+1 cycles.

Test Plan:
- Reset: hold rst=0 with both valids high, then release -> W_en=0, both readies track grant logic; first write appears exactly one edge after first transfer.
- Single source: src0 writes x5=0xDEADBEEF with src1 idle -> src0_ready=1 same cycle; next edge W_en=1, Address_write=5, data_write=0xDEADBEEF; following cycle W_en=0.
- Contention, STARVE_LIMIT=4: src0 valid every cycle (x1..), src1 holding x7=0x1234 -> src1_ready=0 for 4 cycles, starved=1 in the 5th, src1 transfers that cycle. x7 is written the next edge; state returns to PRI0 and src0 resumes.
- x0 drop: src1 writes x0=0xFFFFFFFF -> src1_ready=1, next edge W_en=0, Address_write=0.
- Async reset mid-operation: assert rst=0 between edges during FORCE1 with a pending output write -> W_en, starved and counter clear immediately without a clock; no write occurs.
- Streaming: alternate src0 then src1 valids for 8 cycles with no overlap -> 8 consecutive W_en=1 cycles, correct address/data order, counter never exceeds 0.
